// File: rtl/inst_mem_resp_pkg.sv
// Shared fetch-side constants for the instruction memory responder.
// Bus widths, enable polarities and default memory geometry/latency.
package inst_mem_resp_pkg;

    localparam int          InstAddrBus      = 32;
    localparam int          InstBus          = 32;
    localparam logic [31:0] ZeroWord         = 32'h0000_0000;
    localparam logic        ChipEnable       = 1'b1;
    localparam logic        ChipDisable      = 1'b0;
    localparam logic        RstEnable        = 1'b1;
    localparam logic        WriteEnable      = 1'b1;
    localparam int          InstMemDepthLog2 = 10;
    localparam int          InstMemReadLat   = 2;

endpackage

// File: rtl/inst_mem_array.sv
// Single-port instruction storage: synchronous write, registered synchronous read.
// The read register only updates on re_i, so it holds its last word otherwise.
module inst_mem_array #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] index_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic                  we_i,
    input  logic                  re_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[index_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[index_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_mem_resp.sv
// Instruction memory responder for the fetch stage: wait-state reads, loader writes, error NOPs.
// Optional macro INST_MEM_RANGE_CHECK_EN rejects addresses beyond the storage instead of aliasing.
module inst_mem_resp
    import inst_mem_resp_pkg::*;
#(
    parameter int ADDR_W     = InstAddrBus,
    parameter int DATA_W     = InstBus,
    parameter int DEPTH_LOG2 = InstMemDepthLog2,
    parameter int READ_LAT   = InstMemReadLat
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_valid,
    output logic              stallreq,
    output logic              addr_err
);

    localparam int               CNT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam bit               SINGLE   = (READ_LAT == 1);
    localparam logic [CNT_W-1:0] CNT_INIT = (READ_LAT > 1) ? CNT_W'(READ_LAT - 2) : '0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             instValid_q;
    logic             addrErr_q;
    logic             zeroSel_q;

    logic             inRange;
    logic             reqOk;
    logic             idleAccess;
    logic             badReq;
    logic             goodRead;
    logic             goodWrite;
    logic             memRe;
    logic             memWe;
    logic [DATA_W-1:0] memRdata;

`ifdef INST_MEM_RANGE_CHECK_EN
    assign inRange = (addr[ADDR_W-1:DEPTH_LOG2+2] == '0);
`else
    logic unusedUpperAddr;
    assign unusedUpperAddr = ^addr[ADDR_W-1:DEPTH_LOG2+2];
    assign inRange         = 1'b1;
`endif

    assign reqOk      = (addr[1:0] == 2'b00) && inRange;
    assign idleAccess = (state_q == IDLE) && (ce == ChipEnable);
    assign badReq     = idleAccess && !reqOk;
    assign goodRead   = idleAccess && reqOk && (we != WriteEnable);
    assign goodWrite  = idleAccess && reqOk && (we == WriteEnable);

    // zeroSel_q masks the array output after reset and for injected NOPs,
    // so inst_o stays a registered value without an extra pipeline stage.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            instValid_q <= 1'b0;
            addrErr_q   <= 1'b0;
            zeroSel_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            instValid_q <= memRe || badReq;
            addrErr_q   <= badReq;
            if (badReq) begin
                zeroSel_q <= 1'b1;
            end else if (memRe) begin
                zeroSel_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (goodRead && !SINGLE) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // In WAIT the request inputs are ignored except the held address.
    always_comb begin
        stallreq = 1'b0;
        memRe    = 1'b0;
        memWe    = 1'b0;
        case (state_q)
            IDLE: begin
                if (goodRead) begin
                    if (SINGLE) begin
                        memRe = 1'b1;
                    end else begin
                        stallreq = 1'b1;
                    end
                end
                memWe = goodWrite;
            end
            WAIT: begin
                stallreq = (cnt_q != '0);
                memRe    = (cnt_q == '0);
            end
            default: ;
        endcase
    end

    inst_mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .index_i (addr[DEPTH_LOG2+1:2]),
        .wdata_i (wdata),
        .we_i    (memWe),
        .re_i    (memRe),
        .rdata_o (memRdata)
    );

    assign inst_o     = zeroSel_q ? '0 : memRdata;
    assign inst_valid = instValid_q;
    assign addr_err   = addrErr_q;

endmodule

// File: tb/tb_inst_mem_resp.sv
// Self-checking bench for inst_mem_resp: directed steps plus random traffic against a word-level model.
// Honours INST_MEM_RANGE_CHECK_EN the same way the design does.
module tb_inst_mem_resp;

    localparam int ReadLat   = 2;
    localparam int DepthLog2 = 10;
    localparam int Words     = 1 << DepthLog2;
    localparam int ByteSpan  = Words * 4;
`ifdef INST_MEM_RANGE_CHECK_EN
    localparam bit RangeCheck = 1'b1;
`else
    localparam bit RangeCheck = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic        ce    = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] inst_o;
    logic        inst_valid;
    logic        stallreq;
    logic        addr_err;

    int checks   = 0;
    int failures = 0;

    // Word-level model of storage plus what the registered outputs should show.
    logic [31:0] memModel [Words];
    int          readLeft = 0;
    logic [31:0] readAddr = '0;
    logic        expValid = 1'b0;
    logic        expErr   = 1'b0;
    logic [31:0] expInst  = '0;

    always #5 clock = ~clock;

    inst_mem_resp #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .DEPTH_LOG2 (DepthLog2),
        .READ_LAT   (ReadLat)
    ) dut (
        .clk        (clock),
        .rst        (rst),
        .ce         (ce),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .inst_o     (inst_o),
        .inst_valid (inst_valid),
        .stallreq   (stallreq),
        .addr_err   (addr_err)
    );

    function automatic bit isReject(input logic [31:0] a);
        return ((a % 4) != 0) || (RangeCheck && (a >= ByteSpan));
    endfunction

    function automatic int wordIndex(input logic [31:0] a);
        return int'((a / 4) % Words);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One clock cycle: check the registered outputs from the last edge, drive the
    // inputs for the next edge, predict and check stallreq, then advance the model.
    task automatic applyStimulus(input logic r, input logic c, input logic w,
                                 input logic [31:0] a, input logic [31:0] d);
        logic        expStall;
        logic        nextValid;
        logic        nextErr;
        logic [31:0] nextInst;
        @(negedge clock);
        checkOutput("inst_valid", {31'b0, inst_valid}, {31'b0, expValid});
        checkOutput("addr_err", {31'b0, addr_err}, {31'b0, expErr});
        checkOutput("inst_o", inst_o, expInst);
        rst   = r;
        ce    = c;
        we    = w;
        addr  = a;
        wdata = d;
        nextValid = 1'b0;
        nextErr   = 1'b0;
        nextInst  = expInst;
        if (readLeft == 0 && c) begin
            if (isReject(a)) begin
                nextValid = 1'b1;
                nextErr   = 1'b1;
                nextInst  = '0;
            end else if (w) begin
                memModel[wordIndex(a)] = d;
            end else begin
                readLeft = ReadLat;
                readAddr = a;
            end
        end
        expStall = (readLeft > 1);
        if (readLeft == 1) begin
            nextValid = 1'b1;
            nextInst  = memModel[wordIndex(readAddr)];
        end
        if (readLeft > 0) begin
            readLeft--;
        end
        if (r) begin
            readLeft  = 0;
            nextValid = 1'b0;
            nextErr   = 1'b0;
            nextInst  = '0;
        end
        #1;
        checkOutput("stallreq", {31'b0, stallreq}, {31'b0, expStall});
        expValid = nextValid;
        expErr   = nextErr;
        expInst  = nextInst;
    endtask

    task automatic doWrite(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(1'b0, 1'b1, 1'b1, a, d);
    endtask

    // Holds the address for the whole read; disturb toggles ce/we while waiting.
    task automatic doRead(input logic [31:0] a, input bit disturb);
        applyStimulus(1'b0, 1'b1, 1'b0, a, '0);
        for (int i = 1; i < ReadLat; i++) begin
            applyStimulus(1'b0, !disturb, disturb, a, $urandom);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        end
    endtask

    initial begin
        int          op;
        logic [31:0] a;
        $display("[TB] start, READ_LAT=%0d range_check=%0d", ReadLat, RangeCheck);
        rst = 1'b1;
        repeat (2) @(negedge clock);

        // Reset state and the loader path.
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        doWrite(32'h40, 32'h3C01_0010);
        doWrite(32'h0, 32'h11);
        doWrite(32'h4, 32'h22);
        doWrite(32'h8, 32'h33);
        for (int i = 3; i < 64; i++) begin
            doWrite(32'(i * 4), $urandom);
        end
        doWrite(32'h40, 32'h3C01_0010);

        doRead(32'h40, 1'b0);
        doRead(32'h0, 1'b0);
        doRead(32'h4, 1'b0);
        doRead(32'h8, 1'b0);
        idle(2);

        // Misaligned requests inject a NOP and leave storage alone.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h42, '0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h41, 32'hDEAD_BEEF);
        idle(1);
        doRead(32'h40, 1'b0);

        // Write then immediately read the same word.
        doWrite(32'h8, 32'hCAFE_0008);
        doRead(32'h8, 1'b0);

        // Request lines wiggling during a read must be ignored.
        doRead(32'h4, 1'b1);
        doRead(32'h4, 1'b0);

        // Upper address bits: alias to word 0 or get rejected.
        doRead(32'h1000, 1'b0);
        doWrite(32'h1004, 32'h5555_AAAA);
        doRead(32'h4, 1'b0);
        idle(2);

        // Reset while a read is waiting abandons it.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h40, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h40, '0);
        idle(3);
        doRead(32'h40, 1'b0);

        // Random traffic over the preloaded words.
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 9);
            a  = 32'($urandom_range(0, 63) * 4);
            if ($urandom_range(0, 3) == 0) begin
                a = a | (32'($urandom_range(1, 15)) << (DepthLog2 + 2));
            end
            if (op < 3) begin
                doWrite(a, $urandom);
            end else if (op < 8) begin
                doRead(a, $urandom_range(0, 1) == 1);
            end else begin
                applyStimulus(1'b0, 1'b1, $urandom_range(0, 1) == 1, a | 32'($urandom_range(1, 3)), $urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
